// File: rtl/cpu_pkg.sv
// Shared core constants and types for the register file and its scoreboard.
package cpu_pkg;

  localparam int unsigned D_SIZE   = 32;
  localparam int unsigned R_NUM    = 8;
  localparam int unsigned R_ADDR   = 3;
  localparam int unsigned MAX_PEND = 3;
  localparam int unsigned PEND_W   = $clog2(MAX_PEND + 1);

  typedef logic [R_ADDR-1:0] reg_idx_t;
  typedef logic [PEND_W-1:0] pend_cnt_t;

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
module pend_counter #(
  parameter int unsigned W   = cpu_pkg::PEND_W,
  parameter int unsigned MAX = cpu_pkg::MAX_PEND
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count
);

  import cpu_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && count != W'(MAX)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-back bypass and per-register pending-write
// scoreboard that stalls issue on RAW hazards bypass cannot cover.
module regfile_scoreboard #(
  parameter int unsigned D_SIZE   = cpu_pkg::D_SIZE,
  parameter int unsigned R_NUM    = cpu_pkg::R_NUM,
  parameter int unsigned R_ADDR   = cpu_pkg::R_ADDR,
  parameter int unsigned MAX_PEND = cpu_pkg::MAX_PEND
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [R_ADDR-1:0] rd_addr_a,
  input  logic [R_ADDR-1:0] rd_addr_b,
  input  logic              rd_use_a,
  input  logic              rd_use_b,
  output logic [D_SIZE-1:0] rd_data_a,
  output logic [D_SIZE-1:0] rd_data_b,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [R_ADDR-1:0] issue_dest,
  output logic              stall,
  output logic              issue_fire,
  input  logic              wb_write_en,
  input  logic [R_ADDR-1:0] wb_dest,
  input  logic [D_SIZE-1:0] wb_data,
  input  logic              flush
);

  import cpu_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

  logic [D_SIZE-1:0] regs [R_NUM];
  logic [CNT_W-1:0]  pend [R_NUM];
  logic [R_NUM-1:0]  inc_v;
  logic [R_NUM-1:0]  dec_v;

  logic             hit_a, hit_b;
  logic [CNT_W-1:0] eff_a, eff_b;
  logic             hazard_a, hazard_b, dest_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < R_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write_en) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // A write-back retiring the last pending write in the same cycle is
  // covered by the bypass, so it is discounted before testing the hazard.
  always_comb begin
    hit_a     = wb_write_en && (wb_dest == rd_addr_a);
    hit_b     = wb_write_en && (wb_dest == rd_addr_b);
    rd_data_a = hit_a ? wb_data : regs[rd_addr_a];
    rd_data_b = hit_b ? wb_data : regs[rd_addr_b];
    eff_a     = pend[rd_addr_a] - CNT_W'(hit_a && (pend[rd_addr_a] != '0));
    eff_b     = pend[rd_addr_b] - CNT_W'(hit_b && (pend[rd_addr_b] != '0));
    hazard_a  = rd_use_a && (eff_a != '0);
    hazard_b  = rd_use_b && (eff_b != '0);
    dest_full = issue_wr && (pend[issue_dest] == CNT_W'(MAX_PEND))
                && !(wb_write_en && (wb_dest == issue_dest));
    stall      = issue_valid && (hazard_a || hazard_b || dest_full);
    issue_fire = issue_valid && !stall;
  end

  for (genvar r = 0; r < R_NUM; r++) begin : g_pend
    assign inc_v[r] = issue_fire && issue_wr && (issue_dest == R_ADDR'(r));
    assign dec_v[r] = wb_write_en && (wb_dest == R_ADDR'(r)) && (pend[r] != '0);

    pend_counter #(
      .W   (CNT_W),
      .MAX (MAX_PEND)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_v[r]),
      .dec   (dec_v[r]),
      .clr   (flush),
      .count (pend[r])
    );
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- General-purpose register file for the pipelined RISC core: 8 registers, two combinational read ports for the read stage and one write port driven by the write-back stage (dest_wb, write_en, result_wb).
- Includes a per-register pending-write scoreboard. It is incremented when a register-writing instruction issues and decremented when write-back retires it.
- Raises a stall to the issue logic on RAW hazards that write-back bypass cannot cover.

Parameters:
D_SIZE, 32, register/data width
R_NUM, 8, number of registers
R_ADDR, 3, register index width (log2 R_NUM)
MAX_PEND, 3, maximum in-flight writes tracked per register (counter width 2)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr_a  in  R_ADDR  read port A register index
rd_addr_b  in  R_ADDR  read port B register index
rd_use_a  in  1  issuing instruction actually consumes operand A
rd_use_b  in  1  issuing instruction actually consumes operand B
rd_data_a  out  D_SIZE  operand A value (bypassed)
rd_data_b  out  D_SIZE  operand B value (bypassed)
issue_valid  in  1  instruction presented for issue this cycle
issue_wr  in  1  presented instruction writes a register
issue_dest  in  R_ADDR  destination of presented instruction
stall  out  1  issue must not proceed this cycle
issue_fire  out  1  issue_valid & !stall (instruction accepted)
wb_write_en  in  1  write-back strobe (write_en)
wb_dest  in  R_ADDR  write-back destination (dest_wb)
wb_data  in  D_SIZE  write-back value (result_wb)
flush  in  1  squash all younger in-flight writes; clear scoreboard

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all pending counters = 0. stall and issue_fire are combinational and therefore 0 while issue_valid = 0.
- Register write: on rising clk, if wb_write_en, then reg[wb_dest] <= wb_data. Write latency is 1 cycle, and the value is visible through the array on the next cycle.
- Read: combinational. rd_data_x = wb_data if wb_write_en && wb_dest == rd_addr_x, else reg[rd_addr_x]. Same-cycle write-back to the read register always bypasses.
- Pending count effective for reads: eff_x = pend[rd_addr_x] - (wb_write_en && wb_dest == rd_addr_x && pend[rd_addr_x] != 0).
- hazard_x = rd_use_x && eff_x != 0.
- stall = issue_valid && (hazard_a || hazard_b || (issue_wr && pend[issue_dest] == MAX_PEND && !(wb_write_en && wb_dest == issue_dest))).
- issue_fire = issue_valid && !stall.
- Counter update per register r, on rising clk:
  - inc = issue_fire && issue_wr && issue_dest == r
  - dec = wb_write_en && wb_dest == r && pend[r] != 0
  - inc & dec: no change; inc only: +1; dec only: -1.
  - Never exceeds MAX_PEND and never goes below 0. A write-back to a register with pend == 0 still writes the array and leaves the counter at 0.
- flush: on rising clk, all counters <= 0. Flush overrides inc/dec in the same cycle. A same-cycle wb register write still occurs. stall is not gated by flush.
- R0 is an ordinary writable register (no hardwired zero).
- No other state; no FSM beyond the counters. Reset asserted mid-operation clears counters immediately, including any in-flight pending state.

Decomposition:
- Shared package cpu_pkg: R_ADDR, R_NUM, D_SIZE defaults; reg_idx_t typedef (logic [R_ADDR-1:0]); MAX_PEND constant. The opcode defines used by write_back remain in the existing defines header.
- One sub-module, pend_counter: a single 2-bit saturating up/down counter with inc, dec, clr and count output. It is instantiated R_NUM times via generate.

Test Plan:
- Reset then read: rst_n=0 for 2 cycles, release. rd_addr_a=5, rd_addr_b=7 -> rd_data_a=0, rd_data_b=0, stall=0.
- Write/read and bypass: wb_write_en=1, wb_dest=3, wb_data=0xDEADBEEF with rd_addr_a=3 the same cycle -> rd_data_a=0xDEADBEEF combinationally. Next cycle with wb_write_en=0 -> still 0xDEADBEEF.
- RAW stall:
  - Issue writer to r2 (issue_fire=1) -> pend[2]=1.
  - Next cycle issue_valid=1, rd_use_a=1, rd_addr_a=2 -> stall=1, issue_fire=0.
  - wb_write_en=1, wb_dest=2, wb_data=0x55 -> stall=0, rd_data_a=0x55, pend[2]=0 after edge.
- Saturation:
  - Issue three writers to r4 without write-back -> pend[4]=3.
  - Fourth writer to r4 -> stall=1.
  - Same cycle with wb to r4 -> stall=0, pend stays 3.
- Simultaneous inc/dec and underflow:
  - pend[6]=1, issue writer to r6 and wb to r6 same cycle -> pend[6]=1.
  - wb to r1 with pend[1]=0 -> reg[1] updated, pend[1]=0.
- Flush and async reset:
  - pend[2]=2, pend[5]=1, flush=1 -> all counters 0 next edge; a read of r2 with rd_use_a=1 -> no stall.
  - Assert rst_n=0 mid-cycle -> registers and counters 0 before the next clk edge.
